// File: rtl/mario_pkg.sv
// Shared constants and types for the Mario physics block.
package mario_pkg;

  // USB HID keycodes for the controls
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_J = 8'h0D;

  // Vertical motion state, also exported to the sprite selector
  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    JUMPING  = 2'd1,
    FALLING  = 2'd2
  } air_state_t;

  // Velocities in pixels per frame
  localparam logic [3:0] GRAVITY  = 4'd1;
  localparam logic [3:0] TERM_VEL = 4'd8;
  localparam logic [3:0] WALK_MAX = 4'd3;
  localparam logic [3:0] RUN_MAX  = 4'd6;

  // Playfield limits for the sprite top-left corner
  localparam logic [9:0] X_MIN    = 10'd0;
  localparam logic [9:0] X_MAX    = 10'd624;
  localparam logic [9:0] Y_MIN    = 10'd16;
  localparam logic [9:0] GROUND_Y = 10'd400;
  localparam logic [9:0] X_START  = 10'd64;

  // Widen a 10-bit signed offset to the 11-bit position arithmetic
  function automatic logic [10:0] sext11(input logic [9:0] v);
    return {v[9], v};
  endfunction

endpackage

// File: rtl/key_decode.sv
// Turns four HID keycode bytes into left/right/jump/run key bits.
// The run key is only decoded when MARIO_RUN_EN is defined; otherwise run stays 0.
module key_decode
  import mario_pkg::*;
(
  input  logic [31:0] keycode,
  output logic        left,
  output logic        right,
  output logic        jump,
  output logic        run
);

  // A key is pressed if any of the four report bytes carries its code
  always_comb begin
    left  = 1'b0;
    right = 1'b0;
    jump  = 1'b0;
    run   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode[8*i +: 8] == KEY_A) left  = 1'b1;
      if (keycode[8*i +: 8] == KEY_D) right = 1'b1;
      if (keycode[8*i +: 8] == KEY_W) jump  = 1'b1;
`ifdef MARIO_RUN_EN
      if (keycode[8*i +: 8] == KEY_J) run   = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/mario_physics.sv
// Per-frame movement of the Mario sprite: walking, jumping, falling, landing.
// Optional feature macro: MARIO_RUN_EN (J key raises the walk limit to RUN_MAX).
module mario_physics
  import mario_pkg::*;
(
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycode,
  input  logic [9:0]  jump_x_motion,
  input  logic [9:0]  jump_y_motion,
  output logic        jump_en,
  output logic        hit_ground,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic [1:0]  air_state
);

  logic key_left, key_right, key_jump, key_run;

  air_state_t         state_q, state_d;
  logic [9:0]         pos_x_q, pos_x_d;
  logic [9:0]         pos_y_q, pos_y_d;
  logic signed [3:0]  x_vel_q, x_vel_d;
  logic [3:0]         vel_y_q, vel_y_d;
  logic               seen_motion_q, seen_motion_d;
  logic               zero_frame_q, zero_frame_d;
  logic               w_prev_q, w_prev_d;
  logic               jump_en_q, jump_en_d;
  logic               hit_ground_q, hit_ground_d;

  logic signed [3:0]  walk_max, x_target, x_vel_step;
  logic signed [10:0] x_sum, y_jump_sum;
  logic [10:0]        y_fall_sum;
  logic [3:0]         vel_inc, vel_fall;
  logic               w_rise;

  key_decode u_key_decode (
    .keycode (keycode),
    .left    (key_left),
    .right   (key_right),
    .jump    (key_jump),
    .run     (key_run)
  );

  // Horizontal: ramp x_vel toward the key target, then move and clamp to the walls
  always_comb begin
    walk_max = key_run ? $signed(RUN_MAX) : $signed(WALK_MAX);
    if (key_left && !key_right)      x_target = -walk_max;
    else if (key_right && !key_left) x_target = walk_max;
    else                             x_target = 4'sd0;

    if (x_vel_q < x_target)      x_vel_step = x_vel_q + 4'sd1;
    else if (x_vel_q > x_target) x_vel_step = x_vel_q - 4'sd1;
    else                         x_vel_step = x_vel_q;

    x_sum = $signed({1'b0, pos_x_q} + {{7{x_vel_step[3]}}, x_vel_step} + sext11(jump_x_motion));

    if (x_sum < $signed({1'b0, X_MIN})) begin
      pos_x_d = X_MIN;
      x_vel_d = 4'sd0;
    end else if (x_sum > $signed({1'b0, X_MAX})) begin
      pos_x_d = X_MAX;
      x_vel_d = 4'sd0;
    end else begin
      pos_x_d = x_sum[9:0];
      x_vel_d = x_vel_step;
    end
  end

  // Vertical state machine: jump trigger, upstream-driven ascent, gravity fall, landing
  always_comb begin
    state_d       = state_q;
    pos_y_d       = pos_y_q;
    vel_y_d       = vel_y_q;
    seen_motion_d = seen_motion_q;
    zero_frame_d  = zero_frame_q;
    jump_en_d     = 1'b0;
    hit_ground_d  = 1'b0;
    w_prev_d      = key_jump;
    w_rise        = key_jump && !w_prev_q;

    y_jump_sum = $signed({1'b0, pos_y_q} + sext11(jump_y_motion));
    vel_inc    = vel_y_q + GRAVITY;
    vel_fall   = (vel_inc > TERM_VEL) ? TERM_VEL : vel_inc;
    y_fall_sum = {1'b0, pos_y_q} + {7'd0, vel_fall};

    case (state_q)
      GROUNDED: begin
        if (w_rise) begin
          jump_en_d     = 1'b1;
          state_d       = JUMPING;
          seen_motion_d = 1'b0;
          zero_frame_d  = 1'b0;
        end
      end
      JUMPING: begin
        if (y_jump_sum < $signed({1'b0, Y_MIN})) begin
          pos_y_d = Y_MIN;
          vel_y_d = 4'd0;
          state_d = FALLING;
        end else begin
          pos_y_d = y_jump_sum[9:0];
          if (jump_y_motion != 10'd0) begin
            seen_motion_d = 1'b1;
          end else if (seen_motion_q || zero_frame_q) begin
            vel_y_d = 4'd0;
            state_d = FALLING;
          end else begin
            zero_frame_d = 1'b1;
          end
        end
      end
      FALLING: begin
        if (y_fall_sum >= {1'b0, GROUND_Y}) begin
          pos_y_d      = GROUND_Y;
          vel_y_d      = 4'd0;
          hit_ground_d = 1'b1;
          state_d      = GROUNDED;
        end else begin
          pos_y_d = y_fall_sum[9:0];
          vel_y_d = vel_fall;
        end
      end
      default: state_d = FALLING;
    endcase
  end

  // State and output registers; reset puts Mario standing at the start position
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= GROUNDED;
      pos_x_q       <= X_START;
      pos_y_q       <= GROUND_Y;
      x_vel_q       <= 4'sd0;
      vel_y_q       <= 4'd0;
      seen_motion_q <= 1'b0;
      zero_frame_q  <= 1'b0;
      w_prev_q      <= 1'b0;
      jump_en_q     <= 1'b0;
      hit_ground_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      x_vel_q       <= x_vel_d;
      vel_y_q       <= vel_y_d;
      seen_motion_q <= seen_motion_d;
      zero_frame_q  <= zero_frame_d;
      w_prev_q      <= w_prev_d;
      jump_en_q     <= jump_en_d;
      hit_ground_q  <= hit_ground_d;
    end
  end

  assign jump_en    = jump_en_q;
  assign hit_ground = hit_ground_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign air_state  = state_q;

endmodule

// File: tb/tb_mario_physics.sv
// Self-checking bench for mario_physics: directed scenarios plus randomized key/motion
// traffic compared every frame against an integer model of the movement rules.
module tb_mario_physics;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] keycode = '0;
  logic [9:0]  jump_x_motion = '0;
  logic [9:0]  jump_y_motion = '0;
  logic        jump_en, hit_ground;
  logic [9:0]  pos_x, pos_y;
  logic [1:0]  air_state;

  int checks = 0;
  int failures = 0;

  bit cur_a, cur_d, cur_w, cur_j;
  int cur_jx, cur_jy;

  // Model: mode 0 ground, 1 jump, 2 fall
  int m_mode, m_px, m_py, m_xv, m_vy, m_zero_frames;
  bit m_seen, m_wprev, m_jen, m_hg;
  bit m_valid = 1'b0;

  mario_physics dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .jump_x_motion (jump_x_motion),
    .jump_y_motion (jump_y_motion),
    .jump_en       (jump_en),
    .hit_ground    (hit_ground),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .air_state     (air_state)
  );

  initial forever #5 frame_clk = ~frame_clk;

  task automatic check_eq(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] make_keys(input bit a, input bit d, input bit w, input bit j);
    logic [7:0]  codes [4];
    logic [31:0] kc;
    int n = 0;
    int start;
    for (int i = 0; i < 4; i++) kc[8*i +: 8] = ($urandom % 2 == 0) ? 8'h00 : 8'h2C;
    if (a) begin codes[n] = 8'h04; n++; end
    if (d) begin codes[n] = 8'h07; n++; end
    if (w) begin codes[n] = 8'h1A; n++; end
    if (j) begin codes[n] = 8'h0D; n++; end
    start = int'($urandom % 4);
    for (int k = 0; k < n; k++) kc[8*((start + k) % 4) +: 8] = codes[k];
    return kc;
  endfunction

  task automatic set_keys(input bit a, input bit d, input bit w, input bit j);
    cur_a = a; cur_d = d; cur_w = w; cur_j = j;
    keycode = make_keys(a, d, w, j);
  endtask

  task automatic set_motion(input int jx, input int jy);
    cur_jx = jx; cur_jy = jy;
    jump_x_motion = 10'(jx);
    jump_y_motion = 10'(jy);
  endtask

  task automatic model_reset();
    m_mode = 0; m_px = 64; m_py = 400; m_xv = 0; m_vy = 0;
    m_zero_frames = 0; m_seen = 0; m_wprev = 0; m_jen = 0; m_hg = 0;
  endtask

  task automatic model_step();
    int walk, target, s;
    bit w_rise;
    walk = 3;
`ifdef MARIO_RUN_EN
    if (cur_j) walk = 6;
`endif
    if (cur_a && !cur_d)      target = -walk;
    else if (cur_d && !cur_a) target = walk;
    else                      target = 0;
    if (m_xv < target) m_xv++;
    else if (m_xv > target) m_xv--;
    s = m_px + m_xv + cur_jx;
    if (s < 0)        begin m_px = 0;   m_xv = 0; end
    else if (s > 624) begin m_px = 624; m_xv = 0; end
    else              m_px = s;

    w_rise = cur_w && !m_wprev;
    m_wprev = cur_w;
    m_jen = 0;
    m_hg = 0;
    if (m_mode == 0) begin
      if (w_rise) begin
        m_jen = 1; m_mode = 1; m_seen = 0; m_zero_frames = 0;
      end
    end else if (m_mode == 1) begin
      s = m_py + cur_jy;
      if (s < 16) begin
        m_py = 16; m_vy = 0; m_mode = 2;
      end else begin
        m_py = s;
        if (cur_jy != 0) m_seen = 1;
        else begin
          m_zero_frames++;
          if (m_seen || m_zero_frames >= 2) begin m_vy = 0; m_mode = 2; end
        end
      end
    end else begin
      m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
      s = m_py + m_vy;
      if (s >= 400) begin
        m_py = 400; m_vy = 0; m_hg = 1; m_mode = 0;
      end else m_py = s;
    end
  endtask

  // Model advance on every frame edge or reset, then compare just after the edge
  initial begin
    forever begin
      @(posedge frame_clk or posedge Reset);
      if (Reset) begin
        model_reset();
        m_valid = 1'b1;
      end else if (m_valid) begin
        model_step();
      end
      #1;
      if (m_valid) begin
        check_eq("model_pos_x", int'(pos_x), m_px);
        check_eq("model_pos_y", int'(pos_y), m_py);
        check_eq("model_air_state", int'(air_state), m_mode);
        check_eq("model_jump_en", int'(jump_en), int'(m_jen));
        check_eq("model_hit_ground", int'(hit_ground), int'(m_hg));
        check_eq("pulse_exclusive", int'(jump_en & hit_ground), 0);
      end
    end
  end

  task automatic do_reset();
    @(negedge frame_clk);
    Reset = 1'b1;
    set_keys(0, 0, 0, 0);
    set_motion(0, 0);
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  initial begin
    int cnt, prev_y, max_dy, max_y;
    bit found;
    int exp_x [4] = '{65, 67, 70, 73};
    int exp_y [3] = '{388, 376, 366};
    int jy_seq [3] = '{-12, -12, -10};

    set_keys(0, 0, 0, 0);
    set_motion(0, 0);

    // Reset state
    do_reset();
    check_eq("reset_pos_x", int'(pos_x), 64);
    check_eq("reset_pos_y", int'(pos_y), 400);
    check_eq("reset_air_state", int'(air_state), 0);
    check_eq("reset_jump_en", int'(jump_en), 0);
    check_eq("reset_hit_ground", int'(hit_ground), 0);

    // Single jump with upstream profile -12,-12,-10,0
    set_keys(0, 0, 1, 0);
    @(negedge frame_clk);
    check_eq("jump_en_pulse", int'(jump_en), 1);
    check_eq("jump_state", int'(air_state), 1);
    for (int i = 0; i < 3; i++) begin
      set_motion(0, jy_seq[i]);
      @(negedge frame_clk);
      check_eq("jump_pos_y", int'(pos_y), exp_y[i]);
      check_eq("jump_en_one_frame", int'(jump_en), 0);
    end
    set_motion(0, 0);
    @(negedge frame_clk);
    check_eq("jump_to_falling", int'(air_state), 2);
    cnt = 0;
    repeat (40) begin
      @(negedge frame_clk);
      if (hit_ground) cnt++;
    end
    check_eq("landing_pulses", cnt, 1);
    check_eq("landing_pos_y", int'(pos_y), 400);
    check_eq("landing_state", int'(air_state), 0);
    set_keys(0, 0, 0, 0);

    // Held W yields exactly one jump
    do_reset();
    set_keys(0, 0, 1, 0);
    cnt = 0;
    repeat (100) begin
      @(negedge frame_clk);
      if (jump_en) cnt++;
    end
    check_eq("held_w_jumps", cnt, 1);
    set_keys(0, 0, 0, 0);

    // Walk right into the wall
    do_reset();
    set_keys(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge frame_clk);
      check_eq("walk_pos_x", int'(pos_x), exp_x[i]);
    end
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge frame_clk);
      if (pos_x == 10'd624) found = 1;
    end
    check_eq("reach_right_wall", int'(found), 1);
    repeat (5) begin
      @(negedge frame_clk);
      check_eq("wall_hold_x", int'(pos_x), 624);
    end
    set_keys(0, 0, 0, 0);

    // Long fall from pos_y=300
    do_reset();
    set_keys(0, 0, 1, 0);
    @(negedge frame_clk);
    set_motion(0, -100);
    @(negedge frame_clk);
    check_eq("high_jump_y", int'(pos_y), 300);
    set_motion(0, 0);
    set_keys(0, 0, 0, 0);
    prev_y = 300; max_dy = 0; max_y = 0; cnt = 0;
    repeat (40) begin
      @(negedge frame_clk);
      if (int'(pos_y) - prev_y > max_dy) max_dy = int'(pos_y) - prev_y;
      if (int'(pos_y) > max_y) max_y = int'(pos_y);
      if (hit_ground) cnt++;
      prev_y = int'(pos_y);
    end
    check_eq("terminal_velocity", max_dy, 8);
    check_eq("fall_max_y", max_y, 400);
    check_eq("fall_landings", cnt, 1);

    // Reset in the middle of a jump
    do_reset();
    set_keys(0, 0, 1, 0);
    @(negedge frame_clk);
    set_motion(0, -12);
    @(negedge frame_clk);
    @(negedge frame_clk);
    check_eq("pre_abort_y", int'(pos_y), 376);
    #2;
    Reset = 1'b1;
    set_keys(0, 0, 0, 0);
    set_motion(0, 0);
    @(negedge frame_clk);
    check_eq("abort_pos_y", int'(pos_y), 400);
    check_eq("abort_state", int'(air_state), 0);
    check_eq("abort_hit_ground", int'(hit_ground), 0);
    Reset = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge frame_clk);
      if (hit_ground) cnt++;
    end
    check_eq("abort_no_landing", cnt, 0);

    // Randomized traffic against the model
    do_reset();
    for (int f = 0; f < 3000; f++) begin
      @(negedge frame_clk);
      if (Reset) Reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) Reset = 1'b1;
      if ($urandom_range(0, 3) == 0)
        set_keys(bit'($urandom % 2), bit'($urandom % 2), bit'($urandom_range(0, 2) == 0), bit'($urandom % 2));
      if (m_mode == 1)
        set_motion($urandom_range(0, 8) - 4, ($urandom_range(0, 4) == 0) ? 0 : -$urandom_range(1, 15));
      else
        set_motion($urandom_range(0, 8) - 4, 0);
    end
    Reset = 1'b0;
    @(negedge frame_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mario_physics.md
MARIO_PHYSICS -- requirements
Module: mario_physics

Interface
REQ-001 frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
REQ-002 Reset  in  1  asynchronous, active-high reset.
REQ-003 keycode  in  32  four USB HID keycode bytes; a key counts as pressed if any byte equals its code (A=0x04 left, D=0x07 right, W=0x1A jump, J=0x0D run).
REQ-004 jump_x_motion  in  10  signed per-frame horizontal offset from the upstream jump FSM.
REQ-005 jump_y_motion  in  10  signed per-frame vertical offset from the upstream jump FSM; negative means up.
REQ-006 jump_en  out  1  registered one-frame pulse requesting a jump from the upstream FSM.
REQ-007 hit_ground  out  1  registered one-frame pulse on landing.
REQ-008 pos_x, pos_y  out  10 each  unsigned sprite top-left position.
REQ-009 air_state  out  2  current motion state, for the sprite selector.

Function
REQ-010 The state machine SHALL have states GROUNDED=0, JUMPING=1 and FALLING=2; encoding 3 is unreachable and SHALL recover to FALLING.
REQ-011 W rising edge SHALL be detected against a one-frame-delayed W register, updated every frame in every state.
REQ-012 In GROUNDED, a W rising edge SHALL set jump_en=1 for exactly one frame and move the state to JUMPING on the same edge.
REQ-013 Holding W SHALL never re-trigger a jump; a new press edge is required after landing.
REQ-014 In JUMPING, each frame SHALL do pos_y += jump_y_motion (sign-extended to 11 bits) and set a seen_motion flag when jump_y_motion != 0.
REQ-015 JUMPING SHALL exit to FALLING, with vel_y=0, when any of these holds:
- jump_y_motion == 0 with seen_motion set;
- two frames pass with jump_y_motion == 0 and seen_motion clear (timeout);
- the pos_y result is < Y_MIN. In this case pos_y SHALL clamp to Y_MIN.
REQ-016 In FALLING, each frame SHALL apply vel_y = min(vel_y + GRAVITY, TERM_VEL), then pos_y += the new vel_y.
REQ-017 When the FALLING result is >= GROUND_Y, the block SHALL:
- set pos_y=GROUND_Y and vel_y=0;
- pulse hit_ground for one frame;
- enter GROUNDED.
REQ-018 Horizontal target velocity SHALL be:
- -WALK_MAX with only A pressed;
- +WALK_MAX with only D pressed;
- 0 with neither or both pressed.
REQ-019 x_vel SHALL step by 1 per frame toward the target, never overshooting it, in every state.
REQ-020 Each frame the block SHALL compute pos_x += x_vel + jump_x_motion in 11-bit signed arithmetic.
REQ-021 The pos_x result SHALL clamp to [X_MIN, X_MAX]; on clamping, x_vel SHALL be set to 0.
REQ-022 All outputs SHALL be registered; position latency from a key change is one frame.
REQ-023 jump_en and hit_ground SHALL never be high in the same frame.

Reset
REQ-024 Reset SHALL set: pos_x=X_START (64), pos_y=GROUND_Y (400), x_vel=0, vel_y=0, state=GROUNDED, seen_motion=0, W-delay=0, jump_en=0, hit_ground=0.
REQ-025 Reset asserted mid-jump SHALL abort the jump immediately; no hit_ground pulse SHALL be produced.

Configuration
REQ-026 With MARIO_RUN_EN defined, holding J SHALL raise WALK_MAX from 3 to 6.
REQ-027 When J is released while |x_vel| > 3, x_vel SHALL decay by 1 per frame down to 3.
REQ-028 With MARIO_RUN_EN undefined, J SHALL be ignored and WALK_MAX SHALL be fixed at 3.

Structure
REQ-029 The shared package mario_pkg SHALL hold:
- keycode constants;
- the air_state typedef;
- GRAVITY=1, TERM_VEL=8, WALK_MAX=3, RUN_MAX=6;
- X_MIN=0, X_MAX=624, Y_MIN=16, GROUND_Y=400, X_START=64.
REQ-030 Keycode matching SHALL live in a sub-module key_decode that turns keycode into left/right/jump/run bits.

Verification
REQ-031 Release Reset with no keys -> pos=(64,400), air_state=0, jump_en=0, hit_ground=0.
REQ-032 Press W once, drive jump_y_motion -12,-12,-10,0 -> jump_en high one frame; pos_y 388,376,366; then FALLING; landing produces one hit_ground pulse at pos_y=400.
REQ-033 Hold W for 100 frames -> exactly one jump_en pulse.
REQ-034 Hold D from reset -> x_vel 1,2,3,3; pos_x 65,67,70,73; at 624, x_vel=0 and pos_x stays 624.
REQ-035 Force a fall from pos_y=300 -> vel_y saturates at 8; pos_y never exceeds 400; hit_ground pulses once.
REQ-036 Assert Reset during JUMPING -> next frame pos_y=400, air_state=0, no hit_ground pulse.
